// File: rtl/serial_bit_feeder_if.sv
// Load-side valid/ready handshake carrying one parallel word into serial_bit_feeder.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial stage: shifts a WIDTH-bit word onto x_out, one bit every DIV cycles,
// driving 0 between words so the downstream detector sees a clean zero stream.
//
// state | meaning
// IDLE  | no word in flight, x_out held at 0, ready for a new word
// SHIFT | word in flight, x_out carries the current bit
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_bit_feeder_if.slave  load,
  output logic                x_out,
  output logic                bit_valid,
  output logic                busy,
  output logic                done
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   BIT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       div_cnt, div_cnt_n;
  logic             armed;
  logic             last, accept;
  logic             head_n, x_n, valid_n, done_n;

  // armed keeps load_ready low until the first edge after reset release
  assign last            = (state == SHIFT) && (bit_cnt == '0) && (div_cnt == '0);
  assign load.load_ready = armed && ((state == IDLE) || last);
  assign accept          = load.load_valid && load.load_ready;

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = SHIFT;
          sreg_n    = load.load_data;
          bit_cnt_n = BIT_LAST;
          div_cnt_n = DIV_LAST;
        end
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_n = div_cnt - 8'd1;
        end else if (bit_cnt != '0) begin
          sreg_n    = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
          bit_cnt_n = bit_cnt - CW'(1);
          div_cnt_n = DIV_LAST;
        end else if (accept) begin
          sreg_n    = load.load_data;
          bit_cnt_n = BIT_LAST;
          div_cnt_n = DIV_LAST;
        end else begin
          state_n   = IDLE;
          sreg_n    = '0;
          bit_cnt_n = '0;
          div_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    head_n  = MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0];
    valid_n = (state_n == SHIFT);
    x_n     = valid_n && head_n;
    done_n  = valid_n && (bit_cnt_n == '0) && (div_cnt_n == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      armed     <= 1'b0;
      x_out     <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      bit_cnt   <= bit_cnt_n;
      div_cnt   <= div_cnt_n;
      armed     <= 1'b1;
      x_out     <= x_n;
      bit_valid <= valid_n;
      busy      <= valid_n;
      done      <= done_n;
    end
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial sequence detector (Mealy, "1011" pattern) and drives its one-bit `x` input.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per bit period, with configurable bit order.
- Drives 0 when idle, so the detector sees a clean zero stream between words.

Parameters:
- WIDTH, 8, number of bits per word (legal range 2..32).
- DIV, 1, clock cycles each bit is held on x_out (legal range 1..255). Use 1 when feeding the detector directly.
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- x_out  output  1  serial bit stream, connects to the detector's x.
- bit_valid  output  1  x_out carries a data bit (not idle fill).
- busy  output  1  a word is being shifted.
- done  output  1  one-cycle pulse on the final cycle of a word's last bit.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs return to 0 immediately; any in-flight word is discarded.
  - Outputs are then: x_out=0, bit_valid=0, busy=0, done=0, load_ready=0.
  - Internal state is IDLE, shift register 0, bit counter 0, divider counter 0.
  - load_ready goes to 1 on the first clock edge after reset_n deasserts.
- All outputs are registered except load_ready, which is a combinational decode of state and counters.
- States:
  - IDLE: load_ready=1, busy=0, bit_valid=0, x_out=0.
  - SHIFT: busy=1, bit_valid=1.
- Transfer: a word is accepted on a rising edge where load_valid=1 and load_ready=1.
- IDLE -> SHIFT on accept.
  - Shift register is loaded, bit counter=WIDTH-1, divider=DIV-1.
  - The first bit appears on x_out in the cycle after the accept edge (latency 1).
- SHIFT, bit period:
  - Divider counts down once per cycle.
  - When the divider reaches 0 and the bit counter is not 0: shift to the next bit, decrement the bit counter, reload divider to DIV-1.
  - Each bit is held for exactly DIV cycles; a word occupies WIDTH*DIV cycles.
- Last bit (bit counter 0, divider 0):
  - done=1 for that cycle.
  - load_ready=1 in that same cycle, so back-to-back words are allowed.
- SHIFT exit:
  - If a word is accepted on the last-bit edge: reload and stay in SHIFT. The next word's first bit follows with no gap; bit_valid stays 1.
  - Otherwise: go to IDLE; x_out=0 and bit_valid=0 on the next cycle.
- Bit order:
  - MSB_FIRST=1: output bit WIDTH-1 first, shift left.
  - MSB_FIRST=0: output bit 0 first, shift right.
  - Vacated positions fill with 0.
- Handshake misuse:
  - load_valid while load_ready=0 is ignored; there is no buffering.
  - Upstream must hold load_data and load_valid until accepted.
  - load_data is sampled only on the accept edge; later changes do not affect the word in flight.
- Reset mid-word: the word is lost, done does not pulse, and x_out drops to 0 asynchronously.
- Counter widths: bit counter is clog2(WIDTH) bits; divider is 8 bits. Neither wraps outside its legal range.

Test Plan:
- Single word: WIDTH=8, DIV=1, MSB_FIRST=1, load 8'hB0 at cycle 0.
  - x_out = 1,0,1,1,0,0,0,0 over cycles 1-8.
  - bit_valid high for cycles 1-8; done at cycle 8; load_ready low in cycles 1-7.
  - A downstream detector pulses z once, after the 4th bit.
- Back-to-back: 8'hA5 then 8'h3C with load_valid held high.
  - 16 contiguous bits 10100101 00111100.
  - bit_valid never drops; done at cycles 8 and 16; second accept occurs on cycle 8.
- Bit hold: DIV=3, load 8'h81.
  - x_out=1 for 3 cycles, 0 for 18 cycles, then 1 for 3 cycles.
  - busy high for 24 cycles; done on the 24th cycle.
- LSB order: MSB_FIRST=0, load 8'h0D.
  - x_out = 1,0,1,1,0,0,0,0.
- Reset mid-word: assert reset_n low during bit 4 of 8'hFF.
  - x_out, bit_valid and busy drop to 0 without waiting for a clock edge; no done pulse.
  - load_ready=1 one cycle after release.
  - A new word 8'h0F then shifts out correctly.
- Ignored load: pulse load_valid with 8'h55 while busy and not on the last bit.
  - The current word's stream is unchanged and 8'h55 is never emitted.
